// File: rtl/if_id_queue_if.sv
// IF/ID queue bus: fetch-side handshake, decode-side output and control.
interface if_id_queue_if #(
   parameter int unsigned PC_W   = 32,
   parameter int unsigned INST_W = 32,
   parameter int unsigned CNT_W  = 3
);
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [PC_W-1:0]   pc_i;
   logic [INST_W-1:0] inst_i;
   logic              stall_i;
   logic [PC_W-1:0]   pc_o;
   logic [INST_W-1:0] inst_o;
   logic              valid_o;
   logic [CNT_W-1:0]  occ_o;

   // Pipeline side driving fetch data and decode control
   modport master (
      output flush, in_valid, pc_i, inst_i, stall_i,
      input  in_ready, pc_o, inst_o, valid_o, occ_o
   );

   // Queue side
   modport slave (
      input  flush, in_valid, pc_i, inst_i, stall_i,
      output in_ready, pc_o, inst_o, valid_o, occ_o
   );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID boundary: DEPTH-entry FIFO behind a registered decode-side output.
// An empty FIFO lets a fetched instruction bypass straight into the output
// register; starvation presents a zero bubble; flush empties everything.
module if_id_queue #(
   parameter int unsigned PC_W   = 32,
   parameter int unsigned INST_W = 32,
   parameter int unsigned DEPTH  = 4
) (
   input logic          clk,
   input logic          rst,
   if_id_queue_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 2);
   localparam int unsigned FCW   = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned ENT_W = PC_W + INST_W;

   logic [ENT_W-1:0]  mem [DEPTH];
   logic [FCW-1:0]    count;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PC_W-1:0]   pc_q;
   logic [INST_W-1:0] inst_q;
   logic              valid_q;

   logic fifo_empty;
   logic in_ready_c;
   logic transfer;
   logic advance;
   logic pop;
   logic bypass;
   logic push;

   // Handshake and datapath steering, all derived from registered state
   always_comb begin
      fifo_empty = (count == '0);
      in_ready_c = (count != FCW'(DEPTH));
      transfer   = bus.in_valid & in_ready_c;
      advance    = ~bus.stall_i | ~valid_q;
      pop        = advance & ~fifo_empty;
      bypass     = advance & fifo_empty & transfer;
      push       = transfer & ~bypass;
   end

   assign bus.in_ready = in_ready_c;
   assign bus.pc_o     = pc_q;
   assign bus.inst_o   = inst_q;
   assign bus.valid_o  = valid_q;
   assign bus.occ_o    = CNT_W'(count) + CNT_W'(valid_q);

   // Decode-side output register: flush, then pop, bypass or bubble
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= '0;
         inst_q  <= '0;
         valid_q <= 1'b0;
      end else if (bus.flush) begin
         pc_q    <= '0;
         inst_q  <= '0;
         valid_q <= 1'b0;
      end else if (advance) begin
         if (pop) begin
            {pc_q, inst_q} <= mem[rd_ptr];
            valid_q        <= 1'b1;
         end else if (transfer) begin
            pc_q    <= bus.pc_i;
            inst_q  <= bus.inst_i;
            valid_q <= 1'b1;
         end else begin
            pc_q    <= '0;
            inst_q  <= '0;
            valid_q <= 1'b0;
         end
      end
   end

   // FIFO pointers and occupancy; pointers wrap at DEPTH (power of two)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else if (bus.flush) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + FCW'(1);
         else if (pop && !push) count <= count - FCW'(1);
      end
   end

   // FIFO storage; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (push && !bus.flush) mem[wr_ptr] <= {bus.pc_i, bus.inst_i};
   end
endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue (DEPTH=4) with a scoreboard for the random phase.
module tb_if_id_queue;
   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   if_id_queue_if #(.PC_W(32), .INST_W(32), .CNT_W(3)) bus ();

   if_id_queue #(.PC_W(32), .INST_W(32), .DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
      bus.in_valid = v;
      bus.pc_i     = pc;
      bus.inst_i   = inst;
   endtask

   logic [63:0] q[$];
   logic [63:0] ent;
   int          sent;
   logic        exp_ready;

   initial begin
      rst         = 1'b1;
      bus.flush   = 1'b0;
      bus.stall_i = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      #1;
      chk("rst_valid", 64'(bus.valid_o), 64'd0);
      chk("rst_pc", 64'(bus.pc_o), 64'd0);
      chk("rst_occ", 64'(bus.occ_o), 64'd0);
      chk("rst_ready", 64'(bus.in_ready), 64'd1);
      step();
      step();
      rst = 1'b0;
      step();

      // 1: streaming, one-cycle latency
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 32'h100 + 32'(4 * i), 32'hA000_0000 | 32'(i));
         chk("t1_ready", 64'(bus.in_ready), 64'd1);
         step();
         chk("t1_pc", 64'(bus.pc_o), 64'(32'h100 + 32'(4 * i)));
         chk("t1_inst", 64'(bus.inst_o), 64'(32'hA000_0000 | 32'(i)));
         chk("t1_valid", 64'(bus.valid_o), 64'd1);
         chk("t1_occ", 64'(bus.occ_o), 64'd1);
      end
      drive(1'b0, 32'h0, 32'h0);
      step();
      chk("t1_bubble_valid", 64'(bus.valid_o), 64'd0);
      chk("t1_bubble_pc", 64'(bus.pc_o), 64'd0);
      chk("t1_bubble_occ", 64'(bus.occ_o), 64'd0);

      // 2: stall while pushing 5, 6th refused
      bus.stall_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 32'h200 + 32'(4 * i), 32'hB000_0000 | 32'(i));
         chk("t2_ready", 64'(bus.in_ready), 64'd1);
         step();
         chk("t2_pc_held", 64'(bus.pc_o), 64'h200);
         chk("t2_occ", 64'(bus.occ_o), 64'(i + 1));
      end
      chk("t2_full_ready", 64'(bus.in_ready), 64'd0);
      drive(1'b1, 32'h214, 32'hB000_0005);
      step();
      chk("t2_6th_occ", 64'(bus.occ_o), 64'd5);
      chk("t2_6th_pc", 64'(bus.pc_o), 64'h200);
      chk("t2_6th_ready", 64'(bus.in_ready), 64'd0);

      // 3: release stall, drain in order then bubble
      drive(1'b0, 32'h0, 32'h0);
      bus.stall_i = 1'b0;
      chk("t3_pc0", 64'(bus.pc_o), 64'h200);
      for (int i = 1; i < 5; i++) begin
         step();
         chk("t3_pc", 64'(bus.pc_o), 64'(32'h200 + 32'(4 * i)));
         chk("t3_inst", 64'(bus.inst_o), 64'(32'hB000_0000 | 32'(i)));
         chk("t3_occ", 64'(bus.occ_o), 64'(5 - i));
      end
      step();
      chk("t3_end_pc", 64'(bus.pc_o), 64'd0);
      chk("t3_end_inst", 64'(bus.inst_o), 64'd0);
      chk("t3_end_valid", 64'(bus.valid_o), 64'd0);

      // 4: flush a full queue with a pending input
      bus.stall_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 32'h400 + 32'(4 * i), 32'hC000_0000 | 32'(i));
         step();
      end
      chk("t4_full_occ", 64'(bus.occ_o), 64'd5);
      drive(1'b1, 32'h4FF, 32'hDEAD_BEEF);
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      chk("t4_valid", 64'(bus.valid_o), 64'd0);
      chk("t4_occ", 64'(bus.occ_o), 64'd0);
      chk("t4_ready", 64'(bus.in_ready), 64'd1);
      chk("t4_pc", 64'(bus.pc_o), 64'd0);
      chk("t4_inst", 64'(bus.inst_o), 64'd0);
      bus.stall_i = 1'b0;
      drive(1'b1, 32'h300, 32'hE000_0000);
      step();
      chk("t4_push_pc", 64'(bus.pc_o), 64'h300);
      chk("t4_push_valid", 64'(bus.valid_o), 64'd1);
      chk("t4_push_occ", 64'(bus.occ_o), 64'd1);
      drive(1'b0, 32'h0, 32'h0);
      step();
      chk("t4_after_valid", 64'(bus.valid_o), 64'd0);
      chk("t4_after_occ", 64'(bus.occ_o), 64'd0);

      // 5: async reset mid-operation
      bus.stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h500 + 32'(4 * i), 32'hF000_0000 | 32'(i));
         step();
      end
      drive(1'b0, 32'h0, 32'h0);
      chk("t5_occ_pre", 64'(bus.occ_o), 64'd3);
      #2;
      rst = 1'b1;
      #1;
      chk("t5_occ", 64'(bus.occ_o), 64'd0);
      chk("t5_ready", 64'(bus.in_ready), 64'd1);
      chk("t5_valid", 64'(bus.valid_o), 64'd0);
      chk("t5_pc", 64'(bus.pc_o), 64'd0);
      chk("t5_inst", 64'(bus.inst_o), 64'd0);
      #1;
      rst = 1'b0;
      bus.stall_i = 1'b0;
      step();

      // 6: random stall/valid, scoreboard ordering
      sent = 0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         if (sent == 12 && q.size() == 0) break;
         bus.stall_i = ($urandom_range(0, 3) < 2);
         if (sent < 12 && $urandom_range(0, 3) != 0)
            drive(1'b1, 32'h600 + 32'(4 * sent), 32'h1234_0000 | 32'(sent));
         else
            drive(1'b0, 32'h0, 32'h0);
         chk("t6_occ", 64'(bus.occ_o), 64'(q.size()));
         exp_ready = ((q.size() - int'(bus.valid_o)) != 4);
         chk("t6_ready", 64'(bus.in_ready), 64'(exp_ready));
         if (bus.valid_o && !bus.stall_i) begin
            if (q.size() == 0) begin
               chk("t6_extra", 64'd1, 64'd0);
            end else begin
               ent = q.pop_front();
               chk("t6_pc", 64'(bus.pc_o), 64'(ent[63:32]));
               chk("t6_inst", 64'(bus.inst_o), 64'(ent[31:0]));
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            q.push_back({bus.pc_i, bus.inst_i});
            sent++;
         end
         step();
      end
      chk("t6_done", 64'(sent == 12 && q.size() == 0), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
